// File: rtl/obi_apb_splitter_pkg.sv
// obi_apb_splitter_pkg: shared FSM states and elaboration-time helpers for the OBI-to-APB splitter
package obi_apb_splitter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int NUM_APB_DEF = 3;
  localparam int IDX_W = idx_width(NUM_APB_DEF);
  // windows must be a power of two and the base aligned to one window
  function automatic bit win_cfg_ok(input longint base, input longint win);
    return win > 0 && (win & (win - 1)) == 0 && (base % win) == 0;
  endfunction
endpackage

// File: rtl/obi_apb_addr_decode.sv
// obi_apb_addr_decode: maps an OBI byte address onto one of NUM_APB equal, contiguous windows
module obi_apb_addr_decode
  import obi_apb_splitter_pkg::*;
#(
  parameter int unsigned              OBI_AW    = 32,
  parameter int unsigned              NUM_APB   = 3,
  parameter logic [OBI_AW-1:0]        BASE_ADDR = 32'h0103_0000,
  parameter logic [OBI_AW-1:0]        WIN_SIZE  = 32'h100,
  parameter int unsigned              DEC_IW    = idx_width(NUM_APB)
) (
  input  logic [OBI_AW-1:0] i_addr,
  output logic              o_hit,
  output logic [DEC_IW-1:0] o_idx
);
  localparam int WIN_LG = $clog2(WIN_SIZE);
  // one extra bit so the window end never wraps at the top of the address space
  localparam logic [OBI_AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [OBI_AW:0] HI = LO + (OBI_AW+1)'(NUM_APB) * {1'b0, WIN_SIZE};
  logic [OBI_AW-1:0] w_off;
  assign o_hit = {1'b0, i_addr} >= LO && {1'b0, i_addr} < HI;
  assign w_off = i_addr - BASE_ADDR;
  assign o_idx = DEC_IW'(w_off >> WIN_LG);
endmodule

// File: rtl/obi_apb_splitter_n.sv
// obi_apb_splitter_n: one OBI target fanned out to NUM_APB APB4 completers through a shared FSM
module obi_apb_splitter_n
  import obi_apb_splitter_pkg::*;
#(
  parameter int unsigned       OBI_AW      = 32,
  parameter int unsigned       OBI_DW      = 32,
  parameter int unsigned       OBI_IDW     = 1,
  parameter int unsigned       NUM_APB     = 3,
  parameter logic [OBI_AW-1:0] BASE_ADDR   = 32'h0103_0000,
  parameter logic [OBI_AW-1:0] WIN_SIZE    = 32'h100,
  parameter int unsigned       APB_AW      = 12,
  parameter int unsigned       TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req,
  input  logic                         reqpar,
  output logic                         gnt,
  output logic                         gntpar,
  input  logic [OBI_AW-1:0]            addr,
  input  logic                         we,
  input  logic [OBI_DW/8-1:0]          be,
  input  logic [OBI_DW-1:0]            wdata,
  input  logic [OBI_IDW-1:0]           aid,
  output logic                         rvalid,
  output logic                         rvalidpar,
  input  logic                         rready,
  input  logic                         rreadypar,
  output logic [OBI_DW-1:0]            rdata,
  output logic                         err,
  output logic [OBI_IDW-1:0]           rid,
  output logic [NUM_APB*APB_AW-1:0]    PADDR,
  output logic [NUM_APB-1:0]           PSEL,
  output logic [NUM_APB-1:0]           PENABLE,
  output logic [NUM_APB-1:0]           PWRITE,
  output logic [NUM_APB*OBI_DW-1:0]    PWDATA,
  output logic [NUM_APB*OBI_DW/8-1:0]  PSTRB,
  input  logic [NUM_APB*OBI_DW-1:0]    PRDATA,
  input  logic [NUM_APB-1:0]           PREADY,
  input  logic [NUM_APB-1:0]           PSLVERR
);
  localparam int PORT_IW = idx_width(NUM_APB);
  localparam int WAIT_W  = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int BW      = OBI_DW / 8;
  if (!win_cfg_ok(longint'(BASE_ADDR), longint'(WIN_SIZE))) begin : g_bad_cfg
    $error("obi_apb_splitter_n: WIN_SIZE must be a power of two and BASE_ADDR aligned to it");
  end
  state_e               r_state;
  logic [APB_AW-1:0]    r_addr;
  logic                 r_we;
  logic [BW-1:0]        r_be;
  logic [OBI_DW-1:0]    r_wdata;
  logic [OBI_IDW-1:0]   r_aid;
  logic [PORT_IW-1:0]   r_idx;
  logic [OBI_DW-1:0]    r_rdata;
  logic                 r_err;
  logic [WAIT_W-1:0]    r_wait;
  logic                 w_hit;
  logic [PORT_IW-1:0]   w_idx;
  logic                 w_act;
  logic                 w_pready;
  logic                 w_pslverr;
  logic [OBI_DW-1:0]    w_prdata;
  logic                 w_unused_par;
  obi_apb_addr_decode #(
    .OBI_AW(OBI_AW), .NUM_APB(NUM_APB), .BASE_ADDR(BASE_ADDR), .WIN_SIZE(WIN_SIZE), .DEC_IW(PORT_IW)
  ) u_dec (
    .i_addr(addr), .o_hit(w_hit), .o_idx(w_idx)
  );
  assign w_unused_par = ^{reqpar, rreadypar};
  assign gnt       = req && r_state == IDLE;
  assign gntpar    = ~gnt;
  assign rvalid    = r_state == RESP;
  assign rvalidpar = ~rvalid;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign rid       = r_aid;
  assign w_act     = r_state == SETUP || r_state == ACCESS;
  assign w_pready  = PREADY[r_idx];
  assign w_pslverr = PSLVERR[r_idx];
  assign w_prdata  = PRDATA[int'(r_idx)*OBI_DW +: OBI_DW];
  for (genvar i = 0; i < NUM_APB; i++) begin : g_port
    logic w_sel;
    assign w_sel      = w_act && r_idx == PORT_IW'(i);
    assign PSEL[i]    = w_sel;
    assign PENABLE[i] = w_sel && r_state == ACCESS;
    assign PWRITE[i]  = w_sel && r_we;
    assign PADDR[i*APB_AW +: APB_AW] = w_sel ? r_addr : '0;
    assign PWDATA[i*OBI_DW +: OBI_DW] = w_sel ? r_wdata : '0;
    assign PSTRB[i*BW +: BW] = w_sel && r_we ? r_be : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_aid   <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        IDLE: if (req) begin
          r_addr  <= addr[APB_AW-1:0];
          r_we    <= we;
          r_be    <= be;
          r_wdata <= wdata;
          r_aid   <= aid;
          r_idx   <= w_idx;
          r_wait  <= '0;
          r_err   <= !w_hit;
          r_rdata <= '0;
          r_state <= w_hit ? SETUP : RESP;
        end
        SETUP: r_state <= ACCESS;
        ACCESS: if (w_pready) begin
          r_rdata <= r_we ? '0 : w_prdata;
          r_err   <= w_pslverr;
          r_state <= RESP;
        end else if (TIMEOUT_CYC != 0 && r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
        RESP: if (rready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
